// File: rtl/prio_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: requester count,
// index and hold-counter widths, and FSM state encoding.
package prio_rr_arbiter_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned HOLD_W  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

endpackage : prio_rr_arbiter_pkg

// File: rtl/rr_prio_enc4.sv
// Round-robin winner search over four requesters.
// Ports:
//   req   - request vector, bit i = requester i
//   last  - index of the most recent grant; search starts at last+1
//   idx   - winning index (0 when found=0)
//   found - high when at least one request bit is set
module rr_prio_enc4
   import prio_rr_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   logic [IDX_W-1:0] w_cand;

   // Visit last+1 .. last+4 (mod 4); the first set bit wins, so last itself has lowest priority.
   always_comb begin
      idx    = '0;
      found  = 1'b0;
      w_cand = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_cand = IDX_W'(32'(last) + k);
         if (!found && req[w_cand]) begin
            idx   = w_cand;
            found = 1'b1;
         end
      end
   end

endmodule : rr_prio_enc4

// File: rtl/prio_rr_arbiter.sv
// Four-way round-robin arbiter with a per-grant hold limit.
// An owner keeps the grant while it requests, for at most MAX_HOLD cycles;
// on expiry the grant moves on (or is re-issued to the same owner) and
// preempt pulses for one cycle.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous, active-high reset
//   req     - level request lines
//   gnt     - registered one-hot grant
//   gnt_id  - registered binary owner index (0 when idle)
//   busy    - registered, high while a grant is active
//   preempt - registered one-cycle pulse after a hold-limit release
module prio_rr_arbiter
   import prio_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_id,
   output logic               busy,
   output logic               preempt
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_e         r_state,    w_state;
   logic [NUM_REQ-1:0] r_gnt,      w_gnt;
   logic [IDX_W-1:0]   r_gnt_id,   w_gnt_id;
   logic               r_busy,     w_busy;
   logic               r_preempt,  w_preempt;
   logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt;
   logic [IDX_W-1:0]   r_last,     w_last;

   logic               w_arbitrate;
   logic [IDX_W-1:0]   w_win;
   logic               w_found;

   rr_prio_enc4 u_enc (
      .req   (req),
      .last  (r_last),
      .idx   (w_win),
      .found (w_found)
   );

   // State and output registers; last resets to 3 so requester 0 is searched first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_gnt      <= '0;
         r_gnt_id   <= '0;
         r_busy     <= 1'b0;
         r_preempt  <= 1'b0;
         r_hold_cnt <= '0;
         r_last     <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_state    <= w_state;
         r_gnt      <= w_gnt;
         r_gnt_id   <= w_gnt_id;
         r_busy     <= w_busy;
         r_preempt  <= w_preempt;
         r_hold_cnt <= w_hold_cnt;
         r_last     <= w_last;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state     = r_state;
      w_gnt       = r_gnt;
      w_gnt_id    = r_gnt_id;
      w_busy      = r_busy;
      w_preempt   = 1'b0;
      w_hold_cnt  = r_hold_cnt;
      w_last      = r_last;
      w_arbitrate = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_arbitrate = 1'b1;
         end
         ST_OWN: begin
            if (!req[r_gnt_id]) begin
               // Voluntary release: never flagged as preemption.
               w_arbitrate = 1'b1;
            end else if (r_hold_cnt == HOLD_LAST) begin
               // Hold limit reached; the search starts after the owner, so it
               // is re-granted only if nobody else is requesting.
               w_arbitrate = 1'b1;
               w_preempt   = 1'b1;
            end else if (r_hold_cnt != '1) begin
               w_hold_cnt = r_hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            w_arbitrate = 1'b1;
         end
      endcase

      if (w_arbitrate) begin
         if (w_found) begin
            w_state    = ST_OWN;
            w_gnt      = NUM_REQ'(1) << w_win;
            w_gnt_id   = w_win;
            w_busy     = 1'b1;
            w_hold_cnt = '0;
            w_last     = w_win;
         end else begin
            w_state    = ST_IDLE;
            w_gnt      = '0;
            w_gnt_id   = '0;
            w_busy     = 1'b0;
            w_hold_cnt = '0;
         end
      end
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_gnt_id;
   assign busy    = r_busy;
   assign preempt = r_preempt;

endmodule : prio_rr_arbiter

// File: tb/tb_prio_rr_arbiter.sv
// Self-checking bench for prio_rr_arbiter: directed scenarios plus random
// request traffic against a behavioural owner/queue model.
module tb_prio_rr_arbiter;

   localparam int MAX_HOLD   = 8;
   localparam int STARVE_MAX = 3 * MAX_HOLD + 3;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       preempt;

   int n_checks;
   int n_errors;

   // Reference model: who owns, for how many cycles, who was granted last.
   int m_owner;
   int m_cnt;
   int m_last;
   int m_pre;
   int m_wait [4];

   prio_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .preempt (preempt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 3;
      m_pre   = 0;
      for (int i = 0; i < 4; i++) m_wait[i] = 0;
   endtask

   // One clock edge of the arbitration rules, in plain integer terms.
   task automatic model_step(input logic [3:0] r);
      bit choose;
      choose = 0;
      m_pre  = 0;
      if (m_owner < 0) begin
         choose = 1;
      end else if (r[m_owner] == 1'b0) begin
         choose = 1;
      end else if (m_cnt == MAX_HOLD - 1) begin
         choose = 1;
         m_pre  = 1;
      end else begin
         m_cnt++;
      end
      if (choose) begin
         m_owner = -1;
         for (int k = 1; k <= 4; k++) begin
            if (m_owner < 0 && r[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
         end
         m_cnt = 0;
         if (m_owner >= 0) m_last = m_owner;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] exp_gnt;
      exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      chk({tag, ".gnt"},     32'(gnt),     exp_gnt);
      chk({tag, ".gnt_id"},  32'(gnt_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk({tag, ".busy"},    32'(busy),    (m_owner >= 0) ? 32'd1 : 32'd0);
      chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (reset) model_reset();
      else       model_step(req);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      model_reset();
      #1;
      check_outputs("rst_async");
      step("rst");
      step("rst");
      reset = 1'b0;
   endtask

   initial begin
      int pre_seen;
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b0;
      req      = 4'b0000;
      model_reset();
      #2;

      // All four requesting: rotate with hold-limit preemption.
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 5 * MAX_HOLD; c++) step("all_req");
      chk("all_req.final_owner", 32'(gnt), 32'b0001);

      // Single short request then withdrawal: no preemption.
      do_reset();
      pre_seen = 0;
      req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         step("short");
         chk("short.gnt", 32'(gnt), 32'b0100);
         pre_seen += int'(preempt);
      end
      req = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         step("short_rel");
         pre_seen += int'(preempt);
      end
      chk("short.idle_gnt", 32'(gnt), 32'd0);
      chk("short.no_preempt", 32'(pre_seen), 32'd0);

      // Lone requester: re-granted each hold period, preempt at cycles 9 and 17.
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= 20; c++) begin
         step("lone");
         chk("lone.gnt", 32'(gnt), 32'b0001);
         chk("lone.preempt", 32'(preempt), (c == 9 || c == 17) ? 32'd1 : 32'd0);
      end

      // Owner 1 drops while 0 and 3 wait: 3 follows with no bubble.
      do_reset();
      req = 4'b0010;
      step("handoff_a");
      req = 4'b1011;
      step("handoff_b");
      req = 4'b1001;
      step("handoff_c");
      chk("handoff.next", 32'(gnt), 32'b1000);

      // Reset mid-grant clears outputs without a clock edge.
      do_reset();
      req = 4'b0010;
      step("midrst_grant");
      chk("midrst.pre", 32'(gnt), 32'b0010);
      #3;
      reset = 1'b1;
      #1;
      chk("midrst.gnt", 32'(gnt), 32'd0);
      chk("midrst.busy", 32'(busy), 32'd0);
      model_reset();
      step("midrst_hold");
      reset = 1'b0;
      req = 4'b0011;
      step("midrst_after");
      chk("midrst.first", 32'(gnt), 32'b0001);

      // Random traffic with sticky requests to exercise both release kinds.
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(7) == 0) req[i] = ~req[i];
         end
         step("rand");
         chk("rand.onehot", 32'($onehot0(gnt)), 32'd1);
         for (int i = 0; i < 4; i++) begin
            if (req[i] && !gnt[i]) m_wait[i]++;
            else                   m_wait[i] = 0;
            chk("rand.starve", (m_wait[i] <= STARVE_MAX) ? 32'd1 : 32'd0, 32'd1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_prio_rr_arbiter

// File: doc/prio_rr_arbiter.md
PRIO_RR_ARBITER -- requirements
Module: prio_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one requester may hold the grant (legal 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  request lines, bit i = requester i; level-sensitive, held high while resource is wanted.
REQ-005 Port: gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-006 Port: gnt_id  output  2  binary index of current owner; 0 when busy=0.
REQ-007 Port: busy  output  1  high while any grant bit is high.
REQ-008 Port: preempt  output  1  one-cycle pulse, high in the cycle after a grant was removed by MAX_HOLD expiry.

Function
REQ-009 The block SHALL implement two states: IDLE (no owner) and OWN (exactly one gnt bit high).
REQ-010 In IDLE, on any edge where req != 0, the block SHALL enter OWN with the winner granted; grant latency is exactly 1 cycle from sampled req.
REQ-011 Winner selection SHALL be round-robin: search indices last+1, last+2, last+3, last (mod 4); first index with req set wins.
REQ-012 last SHALL update to the winner index on every new grant (including re-grant to the same requester).
REQ-013 In OWN, grant SHALL hold while req[owner]=1 and hold_cnt < MAX_HOLD-1; hold_cnt increments each owned cycle, saturating at 4 bits, cleared on every new grant.
REQ-014 Release SHALL occur on the edge where req[owner]=0 is sampled (gnt drops next cycle) or where hold_cnt = MAX_HOLD-1 (timeout).
REQ-015 On release, if any other req bit is set, the next winner SHALL be granted on the same edge (no idle bubble); otherwise the block SHALL return to IDLE.
REQ-016 On timeout with only the owner still requesting, the owner SHALL be re-granted on the same edge, hold_cnt cleared, preempt pulsed.
REQ-017 preempt SHALL be asserted for exactly one cycle per timeout release, never on a voluntary release.
REQ-018 gnt SHALL never have more than one bit set; gnt, gnt_id, busy SHALL be mutually consistent every cycle.
REQ-019 A requester raising req while another owns SHALL wait without loss; no request is latched — dropping req before grant withdraws it.
REQ-020 gnt_id, gnt, busy, preempt SHALL be driven directly from registers (no combinational path from req).

Reset
REQ-021 While reset=1: state=IDLE, gnt=4'b0000, gnt_id=0, busy=0, preempt=0, hold_cnt=0, last=3 (so index 0 has first priority after reset).
REQ-022 Reset asserted mid-grant SHALL clear all outputs immediately (asynchronously) and discard the owner.
REQ-023 First edge after reset release SHALL evaluate req normally.

Structure
REQ-024 State encodings, requester count (4) and hold-counter width (4) SHALL live in shared header prio_arb_defs.vh.
REQ-025 Winner search SHALL be a sub-module rr_prio_enc4: combinational, inputs req[3:0] and last[1:0], outputs idx[1:0] and found; instantiated once.
REQ-026 Total RTL 120-400 lines across both modules.

Verification
REQ-027 Reset, then req=4'b1111 held: gnt sequence 0001, 0010, 0100, 1000, 0001 ... each held 8 cycles, preempt pulses after each.
REQ-028 req=4'b0100 for 3 cycles then 0: gnt=0100 from cycle 1 for 3 cycles, then 0000, busy=0, preempt never high.
REQ-029 req=4'b0001 held 20 cycles alone: gnt stays 0001, preempt pulses at cycles 9 and 17, no gnt gap.
REQ-030 Owner 1 drops req while req=4'b1001 pending: next gnt=1000 on following cycle, no idle cycle.
REQ-031 Assert reset while gnt=0010: gnt=0000, busy=0 without waiting for clk; after release with req=4'b0011 first gnt=0001.
REQ-032 Random req stimulus 10000 cycles: checker confirms one-hot gnt, gnt_id/busy consistency, no requester starved beyond 3*MAX_HOLD+3 cycles.
